apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- APB4 requester (initiator) that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers.
- Returns one response per command: read data plus an error flag.
- Sits between an internal controller (DMA, test sequencer, CPU shim) and the APB slaves on the same PCLK domain, e.g. the SRAM-backed APB slave.
- Adds a wait-state timeout so a hung slave cannot stall the requester.

Parameters:
ADDR_WIDTH, 32, width of PADDR and cmd_addr
DATA_WIDTH, 32, width of PWDATA/PRDATA and the command/response data; must be 8, 16 or 32
TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout

Ports:
PCLK  in  1  single clock; all logic on the rising edge
PRESET  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a PCLK edge
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  transfer address
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  DATA_WIDTH/8  write byte strobes
cmd_prot  in  3  protection attributes
rsp_valid  out  1  one-cycle pulse; the response is valid
rsp_rdata  out  DATA_WIDTH  read data (0 for writes or timeout)
rsp_err  out  1  PSLVERR or timeout
busy  out  1  state != IDLE
PSEL, PENABLE, PWRITE  out  1 each  APB control
PADDR  out  ADDR_WIDTH  APB address
PWDATA  out  DATA_WIDTH  APB write data
PSTRB  out  DATA_WIDTH/8  APB strobes
PPROT  out  3  APB protection
PRDATA  in  DATA_WIDTH  APB read data
PREADY, PSLVERR  in  1 each  APB completion and error

Behaviour:
- Reset (PRESET high at an edge): state=IDLE, timeout counter=0.
  - All outputs cleared: PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, rsp_valid, rsp_rdata, rsp_err, busy = 0.
  - A transfer in SETUP or ACCESS is abandoned with no response.
  - PSEL is low from the next cycle.
- FSM states:
  - IDLE: cmd_ready=1. On handshake, register the command onto the APB outputs, PSEL<=1, go to SETUP.
  - SETUP: PSEL=1, PENABLE=0, one cycle exactly. Next state is ACCESS with PENABLE<=1.
  - ACCESS: PSEL=PENABLE=1. Hold until PREADY=1 or timeout.
- cmd_ready = (IDLE) || (ACCESS && PREADY). The second term is combinational on PREADY so back-to-back transfers are possible.
- ACCESS completion, PREADY=1 at an edge:
  - rsp_valid<=1 for one cycle.
  - rsp_err<=PSLVERR. PSLVERR is ignored in every other cycle.
  - rsp_rdata<=PRDATA for reads, 0 for writes.
  - If a new command handshakes in the same cycle: load it, stay PSEL=1, PENABLE<=0, go to SETUP (no IDLE gap). Otherwise PSEL<=0, PENABLE<=0, go to IDLE.
- APB outputs are registered and stable from SETUP through the last ACCESS cycle.
  - PSTRB is forced to 0 for reads.
  - PWDATA keeps the registered value for reads; contents are don't-care.
- Timeout:
  - The counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When TIMEOUT_CYCLES != 0 and the count reaches TIMEOUT_CYCLES: rsp_valid<=1, rsp_err<=1, rsp_rdata<=0, PSEL/PENABLE<=0, go to IDLE.
  - No new command is accepted in the timeout cycle.
  - The counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates; it never wraps.
- Latency, zero-wait slave:
  - Handshake at edge N.
  - PSEL high after N, PENABLE high after N+1.
  - rsp_valid high after N+2.
  - Back-to-back throughput is 2 cycles per transfer.
- There is no response backpressure. The consumer must take rsp_valid in its pulse cycle.
- busy = (state != IDLE). Not asserted during the rsp_valid cycle that returns to IDLE.

Decomposition:
- Shared package apb_pkg:
  - state enum {APB_IDLE, APB_SETUP, APB_ACCESS}.
  - PPROT bit constants (PROT_PRIV=0, PROT_NSEC=1, PROT_INSTR=2).
  - Default width constants, shared with the APB slaves.
- Optional sub-module apb_timeout_counter: clear/enable/expire, parameterised by TIMEOUT_CYCLES. Everything else stays flat.

Test Plan:
1. Write cmd addr 0x10, data 0xDEADBEEF, strb 0xF, zero-wait slave -> PSEL 1 cycle after handshake, PENABLE 1 cycle later, PSTRB=0xF, rsp_valid at +2 with err=0 and rdata=0.
2. Read addr 0x20, slave inserts 3 wait states then returns PRDATA=0x000000A5 -> PENABLE high 4 cycles, PADDR stable at 0x20, PSTRB=0, rsp_rdata=0xA5, rsp_err=0.
3. Write with PSLVERR=1 on the PREADY cycle, and PSLVERR=1 during wait states of a second transfer that completes with 0 -> rsp_err=1 for the first transfer, 0 for the second.
4. PREADY held 0, TIMEOUT_CYCLES=16 -> after 16 ACCESS cycles rsp_valid=1, rsp_err=1, rdata=0, PSEL=0 next cycle; TIMEOUT_CYCLES=0 -> no abort after 100 cycles.
5. cmd_valid held with read 0x4 then write 0x8, zero-wait slave -> PSEL stays high across both, SETUP immediately follows ACCESS, two rsp_valid pulses 2 cycles apart.
6. PRESET asserted during ACCESS with PREADY=0 -> next cycle PSEL=PENABLE=0, busy=0, no rsp_valid; the next command completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Definitions shared by the APB requester and the APB slaves on the same bus:
// FSM states, PPROT bit positions and default bus widths.
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;

  localparam int PROT_PRIV  = 0;
  localparam int PROT_NSEC  = 1;
  localparam int PROT_INSTR = 2;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_e;

  // A timeout of 0 still needs a 1-bit counter to keep the declaration legal.
  function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// Saturating wait-state counter; flags the cycle in which the count reaches
// TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 never expires.
module apb_timeout_counter
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned CNT_W    = timeout_cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned LAST_INT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LAST_INT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the always blocks are evaluated.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + ONE;
    end
  end

  // Expiry fires on the edge that would take the count to LIMIT.
  assign o_expire = (TIMEOUT_CYCLES != 0) && i_enable && (r_count == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// APB4 requester: turns a valid/ready command stream into SETUP/ACCESS
// transfers and returns one response pulse per command, with a wait-state timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int          ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int          DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [2:0]              PPROT,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  apb_state_e r_state;
  apb_state_e w_state_next;

  logic                    r_psel;
  logic                    r_penable;
  logic                    r_pwrite;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic [DATA_WIDTH/8-1:0] r_pstrb;
  logic [2:0]              r_pprot;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                    r_rsp_err;

  logic w_in_access;
  logic w_handshake;
  logic w_done;
  logic w_expire;
  logic w_cnt_clear;
  logic w_cnt_enable;

  assign w_in_access  = (r_state == APB_ACCESS);
  // Accepting during the completing ACCESS cycle lets transfers run back to back.
  assign cmd_ready    = (r_state == APB_IDLE) || (w_in_access && PREADY);
  assign w_handshake  = cmd_valid && cmd_ready;
  assign w_done       = w_in_access && PREADY;
  assign w_cnt_clear  = (r_state == APB_SETUP);
  assign w_cnt_enable = w_in_access && !PREADY;

  apb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk   (PCLK),
    .i_rst   (PRESET),
    .i_clear (w_cnt_clear),
    .i_enable(w_cnt_enable),
    .o_expire(w_expire)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= APB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the next-state default is assigned before the case, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      APB_IDLE: begin
        if (w_handshake) w_state_next = APB_SETUP;
      end
      APB_SETUP: begin
        w_state_next = APB_ACCESS;
      end
      APB_ACCESS: begin
        if (w_done)        w_state_next = w_handshake ? APB_SETUP : APB_IDLE;
        else if (w_expire) w_state_next = APB_IDLE;
      end
      default: begin
        w_state_next = APB_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_pprot     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;

      if (w_handshake) begin
        r_psel    <= 1'b1;
        r_penable <= 1'b0;
        r_pwrite  <= cmd_write;
        r_paddr   <= cmd_addr;
        r_pwdata  <= cmd_wdata;
        r_pstrb   <= cmd_write ? cmd_strb : '0;
        r_pprot   <= cmd_prot;
      end else if (r_state == APB_SETUP) begin
        r_penable <= 1'b1;
      end else if (w_done || w_expire) begin
        r_psel    <= 1'b0;
        r_penable <= 1'b0;
      end

      // PSLVERR and PRDATA are only meaningful on the PREADY cycle.
      if (w_done) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= PSLVERR;
        r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
      end else if (w_expire) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b1;
        r_rsp_rdata <= '0;
      end
    end
  end

  assign busy      = (r_state != APB_IDLE);
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign PSTRB     = r_pstrb;
  assign PPROT     = r_pprot;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: a slave model answers each transfer
// from a per-command plan, and a negedge monitor checks the bus and responses.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int TO = 16;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    logic        err;
    logic [31:0] rdata;
  } txn_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  logic PCLK = 1'b0;
  logic PRESET;

  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic        PREADY, PSLVERR;

  logic        z_cmd_valid, z_cmd_ready, z_cmd_write;
  logic [31:0] z_cmd_addr, z_cmd_wdata;
  logic [3:0]  z_cmd_strb;
  logic [2:0]  z_cmd_prot;
  logic        z_rsp_valid, z_rsp_err, z_busy;
  logic [31:0] z_rsp_rdata;
  logic        z_PSEL, z_PENABLE, z_PWRITE;
  logic [31:0] z_PADDR, z_PWDATA, z_PRDATA;
  logic [3:0]  z_PSTRB;
  logic [2:0]  z_PPROT;
  logic        z_PREADY, z_PSLVERR;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  txn_t apb_q[$];
  txn_t slv_q[$];
  rsp_t rsp_q[$];

  int last_hs_edge  = 0;
  int setup_cyc     = 0;
  int acc_start_cyc = 0;
  int rsp_prev_cyc  = 0;
  int rsp_last_cyc  = 0;
  bit mon_flush     = 1'b0;

  apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) u_dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(0)) u_dut_noto (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(z_cmd_valid), .cmd_ready(z_cmd_ready), .cmd_write(z_cmd_write),
    .cmd_addr(z_cmd_addr), .cmd_wdata(z_cmd_wdata), .cmd_strb(z_cmd_strb), .cmd_prot(z_cmd_prot),
    .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err), .busy(z_busy),
    .PSEL(z_PSEL), .PENABLE(z_PENABLE), .PWRITE(z_PWRITE), .PADDR(z_PADDR), .PWDATA(z_PWDATA),
    .PSTRB(z_PSTRB), .PPROT(z_PPROT), .PRDATA(z_PRDATA), .PREADY(z_PREADY), .PSLVERR(z_PSLVERR)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: what the requester must report for one command.
  function automatic rsp_t model_rsp(input txn_t t);
    rsp_t r;
    r.tmo   = (TO != 0) && (t.waits >= TO);
    r.err   = r.tmo ? 1'b1 : t.err;
    r.rdata = (r.tmo || t.write) ? 32'h0 : t.rdata;
    return r;
  endfunction

  function automatic int model_len(input txn_t t);
    return ((TO != 0) && (t.waits >= TO)) ? TO : t.waits + 1;
  endfunction

  function automatic txn_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int waits, input logic e,
                              input logic [31:0] rd);
    txn_t t;
    t.write = w; t.addr = a; t.wdata = d; t.strb = s; t.prot = 3'b000;
    t.prot[PROT_NSEC] = 1'b1;
    t.waits = waits; t.err = e; t.rdata = rd;
    return t;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send(input txn_t t);
    int  n    = 0;
    bit  done = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = t.write;
    cmd_addr  = t.addr;
    cmd_wdata = t.wdata;
    cmd_strb  = t.strb;
    cmd_prot  = t.prot;
    while (!done) begin
      @(negedge PCLK);
      if (cmd_ready) begin
        done = 1'b1;
        last_hs_edge = cyc + 1;
        apb_q.push_back(t);
        slv_q.push_back(t);
        rsp_q.push_back(model_rsp(t));
      end else if (++n > 200) begin
        check("cmd_ready_wait", 72'(cmd_ready), 72'd1);
        done = 1'b1;
      end
      @(posedge PCLK); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((rsp_q.size() != 0 || busy) && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    if (n >= 200) check("drain_timeout", 72'(rsp_q.size()), 72'd0);
    @(posedge PCLK); #1;
  endtask

  // Slave model: each ACCESS run answers from the next plan in slv_q.
  txn_t slv_cur;
  bit   slv_active = 1'b0;
  int   slv_cnt    = 0;
  always @(posedge PCLK) begin
    #1;
    if (PSEL && PENABLE) begin
      if (!slv_active) begin
        slv_active = 1'b1;
        slv_cnt    = 0;
        if (slv_q.size() > 0) slv_cur = slv_q.pop_front();
        else slv_cur = mk(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, 32'h0);
      end
      if (slv_cnt == slv_cur.waits) begin
        PREADY = 1'b1; PSLVERR = slv_cur.err; PRDATA = slv_cur.rdata;
      end else begin
        PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = $urandom;
      end
      slv_cnt++;
    end else begin
      slv_active = 1'b0;
      PREADY  = 1'($urandom_range(0, 1));
      PSLVERR = 1'($urandom_range(0, 1));
      PRDATA  = $urandom;
    end
  end

  // Monitor: bus stability, phase lengths and responses against the scoreboard.
  txn_t mon_cur;
  int   cur_len   = 0;
  int   acc_len   = 0;
  int   setup_run = 0;
  always @(negedge PCLK) begin : monitor
    rsp_t        e;
    logic [71:0] act_f;
    logic [71:0] exp_f;
    if (mon_flush) begin
      acc_len   = 0;
      setup_run = 0;
      mon_flush = 1'b0;
    end
    if (!(PSEL && PENABLE) && acc_len != 0) begin
      check("access_len", 72'(acc_len), 72'(cur_len));
      acc_len = 0;
    end
    if (PSEL && !PENABLE) begin
      if (setup_run == 0) begin
        if (apb_q.size() == 0) begin
          check("setup_without_cmd", 72'(PSEL), 72'd0);
        end else begin
          mon_cur   = apb_q.pop_front();
          cur_len   = model_len(mon_cur);
          setup_cyc = cyc;
        end
      end
      setup_run++;
    end
    if (PSEL) begin
      act_f = {PADDR, PWRITE, PPROT, PSTRB, (PWRITE ? PWDATA : 32'h0)};
      exp_f = {mon_cur.addr, mon_cur.write, mon_cur.prot,
               (mon_cur.write ? mon_cur.strb : 4'h0),
               (mon_cur.write ? mon_cur.wdata : 32'h0)};
      check("apb_fields", act_f, exp_f);
    end
    if (PSEL && PENABLE) begin
      if (acc_len == 0) begin
        check("setup_len", 72'(setup_run), 72'd1);
        setup_run     = 0;
        acc_start_cyc = cyc;
      end
      acc_len++;
    end
    if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", 72'(rsp_valid), 72'd0);
      end else begin
        e = rsp_q.pop_front();
        check("rsp_rdata", 72'(rsp_rdata), 72'(e.rdata));
        check("rsp_err", 72'(rsp_err), 72'(e.err));
        if (e.tmo) check("timeout_idle", 72'({PSEL, PENABLE, busy}), 72'd0);
        rsp_prev_cyc = rsp_last_cyc;
        rsp_last_cyc = cyc;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int   hs_a;
    txn_t t;

    PRESET = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = '0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    z_cmd_valid = 1'b0; z_cmd_write = 1'b0; z_cmd_addr = '0; z_cmd_wdata = '0;
    z_cmd_strb = '0; z_cmd_prot = '0;
    z_PREADY = 1'b0; z_PSLVERR = 1'b0; z_PRDATA = '0;

    // Reset values
    repeat (2) @(negedge PCLK);
    check("reset_ctl", 72'({PSEL, PENABLE, PWRITE, PSTRB, PPROT, rsp_valid, rsp_err, busy, cmd_ready}),
          72'd1);
    check("reset_bus", 72'({PADDR, PWDATA}), 72'd0);
    check("reset_rdata", 72'(rsp_rdata), 72'd0);
    check("reset_noto", 72'({z_PSEL, z_PENABLE, z_busy, z_rsp_valid}), 72'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;

    // Zero-wait write: SETUP at N, ACCESS at N+1, response at N+2
    send(mk(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0));
    wait_drain();
    check("lat_psel", 72'(setup_cyc), 72'(last_hs_edge));
    check("lat_penable", 72'(acc_start_cyc), 72'(last_hs_edge + 1));
    check("lat_rsp", 72'(rsp_last_cyc), 72'(last_hs_edge + 2));

    // Read with three wait states; strobes must be dropped
    send(mk(1'b0, 32'h20, 32'h1234_5678, 4'hF, 3, 1'b0, 32'h0000_00A5));
    check("busy_mid", 72'(busy), 72'd1);
    wait_drain();

    // Error on the PREADY cycle, then error noise only during wait states
    send(mk(1'b1, 32'h30, 32'h1, 4'h3, 0, 1'b1, 32'h0));
    wait_drain();
    send(mk(1'b1, 32'h34, 32'h2, 4'hC, 3, 1'b0, 32'h0));
    wait_drain();

    // Timeout boundary: 15 wait states completes, 16 aborts
    send(mk(1'b0, 32'h50, 32'h0, 4'h0, 15, 1'b0, 32'hCAFE_0015));
    wait_drain();
    send(mk(1'b0, 32'h54, 32'h0, 4'h0, 16, 1'b0, 32'hCAFE_0016));
    wait_drain();
    send(mk(1'b1, 32'h58, 32'h77, 4'h1, 40, 1'b0, 32'h0));
    wait_drain();

    // Back-to-back read then write
    send(mk(1'b0, 32'h4, 32'h0, 4'h0, 0, 1'b0, 32'h0BAD_F00D));
    hs_a = last_hs_edge;
    send(mk(1'b1, 32'h8, 32'h5555_AAAA, 4'hA, 0, 1'b0, 32'h0));
    wait_drain();
    check("b2b_gap", 72'(rsp_last_cyc - rsp_prev_cyc), 72'd2);
    check("b2b_span", 72'(rsp_last_cyc - hs_a), 72'd4);

    // Reset in the middle of a stalled ACCESS
    send(mk(1'b0, 32'h40, 32'h0, 4'h0, 1000, 1'b0, 32'h0));
    repeat (3) @(posedge PCLK);
    #1;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    mon_flush = 1'b1;
    apb_q.delete();
    slv_q.delete();
    rsp_q.delete();
    @(negedge PCLK);
    check("abort_reset", 72'({PSEL, PENABLE, busy, rsp_valid}), 72'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    send(mk(1'b1, 32'h44, 32'h600D_600D, 4'hF, 2, 1'b0, 32'h0));
    wait_drain();

    // Randomized traffic
    for (int i = 0; i < 120; i++) begin
      t.write = 1'($urandom_range(0, 1));
      t.addr  = $urandom;
      t.wdata = $urandom;
      t.strb  = 4'($urandom);
      t.prot  = 3'($urandom);
      t.err   = 1'($urandom_range(0, 1));
      t.rdata = $urandom;
      t.waits = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20))
                                            : int'($urandom_range(0, 3));
      send(t);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge PCLK);
        #1;
      end
    end
    wait_drain();

    // TIMEOUT_CYCLES = 0: a stalled slave is waited on indefinitely
    z_cmd_valid = 1'b1; z_cmd_write = 1'b0; z_cmd_addr = 32'h30;
    z_PREADY = 1'b0;
    @(negedge PCLK);
    check("noto_cmd_ready", 72'(z_cmd_ready), 72'd1);
    @(posedge PCLK); #1;
    z_cmd_valid = 1'b0;
    begin
      int z_rsp_cnt = 0;
      repeat (100) begin
        @(negedge PCLK);
        if (z_rsp_valid) z_rsp_cnt++;
      end
      check("noto_no_abort", 72'(z_rsp_cnt), 72'd0);
    end
    check("noto_access", 72'({z_PSEL, z_PENABLE, z_PADDR}), 72'({2'b11, 32'h30}));
    @(posedge PCLK); #1;
    z_PREADY = 1'b1; z_PSLVERR = 1'b0; z_PRDATA = 32'h1234_5678;
    @(posedge PCLK); #1;
    z_PREADY = 1'b0;
    @(negedge PCLK);
    check("noto_rsp", 72'({z_rsp_valid, z_rsp_err, z_rsp_rdata, z_PSEL}),
          72'({1'b1, 1'b0, 32'h1234_5678, 1'b0}));

    repeat (2) @(posedge PCLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
